// File: rtl/mem_arb.sv
// Round-robin arbiter and sequencer for one single-port SRAM shared by two requesters; 0-cycle grant, read data in the cycle after the handshake.
// Backpressure: a read response that is not yet accepted stalls every macro access, so the returned word stays stable.
module mem_arb #(
    parameter int E = 256,
    parameter int W = 32,
    localparam int AW = $clog2(E),
    localparam int NBYTE = W / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_req_valid,
    output logic             p0_req_ready,
    input  logic             p0_req_we,
    input  logic [NBYTE-1:0] p0_req_be,
    input  logic [AW-1:0]    p0_req_addr,
    input  logic [W-1:0]     p0_req_wdata,
    output logic             p0_rsp_valid,
    input  logic             p0_rsp_ready,
    output logic [W-1:0]     p0_rsp_rdata,
    input  logic             p1_req_valid,
    output logic             p1_req_ready,
    input  logic             p1_req_we,
    input  logic [NBYTE-1:0] p1_req_be,
    input  logic [AW-1:0]    p1_req_addr,
    input  logic [W-1:0]     p1_req_wdata,
    output logic             p1_rsp_valid,
    input  logic             p1_rsp_ready,
    output logic [W-1:0]     p1_rsp_rdata,
    output logic             mem_ce_n,
    output logic             mem_we_n,
    output logic [NBYTE-1:0] mem_be,
    output logic [AW-1:0]    mem_addr,
    output logic [W-1:0]     mem_wdata,
    input  logic [W-1:0]     mem_rdata
);

    typedef struct packed {
        logic             we;
        logic [NBYTE-1:0] be;
        logic [AW-1:0]    addr;
        logic [W-1:0]     wdata;
    } req_t;

    logic prio;
    logic rsp_pend;
    logic rsp_id;

    req_t req0, req1, win;
    logic sel_rsp_ready, stall, can_grant, gnt0, gnt1, gnt, rsp_acc;

    assign req0 = '{we: p0_req_we, be: p0_req_be, addr: p0_req_addr, wdata: p0_req_wdata};
    assign req1 = '{we: p1_req_we, be: p1_req_be, addr: p1_req_addr, wdata: p1_req_wdata};

    // Accepting the pending response in the same cycle frees the slot for a new grant.
    assign sel_rsp_ready = rsp_id ? p1_rsp_ready : p0_rsp_ready;
    assign stall         = rsp_pend & ~sel_rsp_ready;
    assign rsp_acc       = rsp_pend & sel_rsp_ready;
    assign can_grant     = rst_n & ~stall;

    assign gnt0 = can_grant & p0_req_valid & (~p1_req_valid | ~prio);
    assign gnt1 = can_grant & p1_req_valid & (~p0_req_valid | prio);
    assign gnt  = gnt0 | gnt1;

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;
    assign win          = gnt1 ? req1 : req0;

    always_comb begin
        mem_ce_n  = 1'b1;
        mem_we_n  = 1'b1;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt) begin
            mem_ce_n  = 1'b0;
            mem_we_n  = ~win.we;
            mem_be    = win.we ? win.be : '0;
            mem_addr  = win.addr;
            mem_wdata = win.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            rsp_pend <= 1'b0;
            rsp_id   <= 1'b0;
        end else begin
            if (gnt) begin
                prio <= gnt0;
            end
            if (gnt && !win.we) begin
                rsp_pend <= 1'b1;
                rsp_id   <= gnt1;
            end else if (rsp_acc) begin
                rsp_pend <= 1'b0;
            end
        end
    end

    // The macro output register holds the word read at the handshake until the next access.
    assign p0_rsp_valid = rst_n & rsp_pend & ~rsp_id;
    assign p1_rsp_valid = rst_n & rsp_pend & rsp_id;
    assign p0_rsp_rdata = mem_rdata;
    assign p1_rsp_rdata = mem_rdata;

endmodule
